// File: rtl/reqfifo_pkg.sv
// Shared types for the banked operand request FIFO: queued entry layout,
// per-bank arbitration outcome and a constant log2 helper.
package reqfifo_pkg;

    // Entry fields are sized for the widest supported row/ocid; users slice down.
    localparam int ROW_W_MAX  = 16;
    localparam int OCID_W_MAX = 15;

    typedef struct packed {
        logic [ROW_W_MAX-1:0]  row;
        logic [OCID_W_MAX-1:0] ocid;
        logic                  src_sel;
    } req_entry_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_WR   = 2'd1,
        ARB_RD   = 2'd2
    } arb_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/reqfifo_bank_q.sv
// Single-bank request FIFO: up to two pushes (tail, tail+1) and one pop per cycle,
// exposing the head entry and the occupancy count.
module reqfifo_bank_q
    import reqfifo_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       push_n,
    input  req_entry_t       push0,
    input  req_entry_t       push1,
    input  logic             pop,
    output req_entry_t       head,
    output logic [CNT_W-1:0] count
);

    req_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_inc;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer arithmetic relies on DEPTH being a power of two to wrap for free.
    always_comb begin
        wr_ptr_inc = wr_ptr_q + 1'b1;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_n);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push_n) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_n != 2'd0) mem_q[wr_ptr_q]   <= push0;
        if (push_n == 2'd2) mem_q[wr_ptr_inc] <= push1;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: rtl/reqfifo_banked.sv
// Banked operand request queue: per-bank FIFOs of src1/src2 reads merged with
// CDB writebacks, writes first unless a bank's queued reads are being starved.
module reqfifo_banked
    import reqfifo_pkg::*;
#(
    parameter  int NUM_BANKS  = 4,
    parameter  int ROW_W      = 3,
    parameter  int OCID_W     = 3,
    parameter  int DEPTH      = 4,
    parameter  int DATA_W     = 256,
    parameter  int STARVE_MAX = 3,
    localparam int BANK_W     = clog2(NUM_BANKS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            src1_valid,
    input  logic [BANK_W-1:0]               src1_bank,
    input  logic [ROW_W-1:0]                src1_row,
    input  logic [OCID_W-1:0]               src1_ocid,
    input  logic                            src2_valid,
    input  logic [BANK_W-1:0]               src2_bank,
    input  logic [ROW_W-1:0]                src2_row,
    input  logic [OCID_W-1:0]               src2_ocid,
    output logic                            req_ready,
    input  logic                            wr_valid,
    input  logic [BANK_W-1:0]               wr_bank,
    input  logic [ROW_W-1:0]                wr_row,
    input  logic [DATA_W-1:0]               wr_data,
    output logic                            wr_ready,
    output logic [NUM_BANKS-1:0]            rf_valid,
    output logic [NUM_BANKS-1:0]            rf_wr,
    output logic [NUM_BANKS*ROW_W-1:0]      rf_addr,
    output logic [NUM_BANKS*(OCID_W+1)-1:0] rf_ocid,
    output logic [NUM_BANKS*DATA_W-1:0]     rf_wdata
);

    localparam int CNT_W = clog2(DEPTH) + 1;
    localparam int STV_W = clog2(STARVE_MAX + 1);
    localparam int OC_W  = OCID_W + 1;

    req_entry_t           src1_entry, src2_entry;
    logic                 accept;
    logic [NUM_BANKS-1:0] room;
    logic [NUM_BANKS-1:0] blocked;

    always_comb begin
        src1_entry         = '0;
        src1_entry.row     = ROW_W_MAX'(src1_row);
        src1_entry.ocid    = OCID_W_MAX'(src1_ocid);
        src1_entry.src_sel = 1'b0;
        src2_entry         = '0;
        src2_entry.row     = ROW_W_MAX'(src2_row);
        src2_entry.ocid    = OCID_W_MAX'(src2_ocid);
        src2_entry.src_sel = 1'b1;
    end

    // Room is judged on pre-pop occupancy so acceptance never depends on arbitration.
    assign req_ready = &room;
    assign accept    = req_ready && (src1_valid || src2_valid);
    assign wr_ready  = ~blocked[wr_bank];

    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic             hit1, hit2;
        logic [1:0]       need;
        logic [1:0]       push_n;
        req_entry_t       push0, push1, head;
        logic [CNT_W-1:0] count;
        logic             pop;
        arb_e             arb;
        logic [STV_W-1:0] starve_q, starve_d;
        logic             rf_valid_q, rf_valid_d;
        logic             rf_wr_q, rf_wr_d;
        logic [ROW_W-1:0] rf_addr_q, rf_addr_d;
        logic [OC_W-1:0]  rf_ocid_q, rf_ocid_d;
        logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
        logic             unused_head;

        assign hit1        = src1_valid && (src1_bank == BANK_W'(gi));
        assign hit2        = src2_valid && (src2_bank == BANK_W'(gi));
        assign unused_head = ^head;

        always_comb begin
            need       = 2'(hit1) + 2'(hit2);
            push_n     = accept ? need : 2'd0;
            // When only src2 targets this bank it takes the tail slot itself.
            push0      = hit1 ? src1_entry : src2_entry;
            push1      = src2_entry;
            arb        = ARB_IDLE;
            if (wr_valid && (wr_bank == BANK_W'(gi)) && !blocked[gi]) begin
                arb = ARB_WR;
            end else if (count != '0) begin
                arb = ARB_RD;
            end
            pop        = (arb == ARB_RD);

            starve_d   = starve_q;
            if ((count == '0) || (arb == ARB_RD)) begin
                starve_d = '0;
            end else if ((arb == ARB_WR) && (starve_q != STV_W'(STARVE_MAX))) begin
                starve_d = starve_q + 1'b1;
            end

            rf_valid_d = (arb != ARB_IDLE);
            rf_wr_d    = (arb == ARB_WR);
            rf_addr_d  = '0;
            rf_ocid_d  = '0;
            rf_wdata_d = '0;
            if (arb == ARB_WR) begin
                rf_addr_d  = wr_row;
                rf_wdata_d = wr_data;
            end else if (arb == ARB_RD) begin
                rf_addr_d  = head.row[ROW_W-1:0];
                rf_ocid_d  = {head.src_sel, head.ocid[OCID_W-1:0]};
            end
        end

        assign room[gi]    = (CNT_W'(DEPTH) - count) >= CNT_W'(need);
        assign blocked[gi] = (starve_q == STV_W'(STARVE_MAX)) && (count != '0);

        reqfifo_bank_q #(
            .DEPTH (DEPTH)
        ) u_q (
            .clk    (clk),
            .rst    (rst),
            .push_n (push_n),
            .push0  (push0),
            .push1  (push1),
            .pop    (pop),
            .head   (head),
            .count  (count)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                starve_q   <= '0;
                rf_valid_q <= 1'b0;
                rf_wr_q    <= 1'b0;
                rf_addr_q  <= '0;
                rf_ocid_q  <= '0;
                rf_wdata_q <= '0;
            end else begin
                starve_q   <= starve_d;
                rf_valid_q <= rf_valid_d;
                rf_wr_q    <= rf_wr_d;
                rf_addr_q  <= rf_addr_d;
                rf_ocid_q  <= rf_ocid_d;
                rf_wdata_q <= rf_wdata_d;
            end
        end

        assign rf_valid[gi]                  = rf_valid_q;
        assign rf_wr[gi]                     = rf_wr_q;
        assign rf_addr[gi*ROW_W +: ROW_W]    = rf_addr_q;
        assign rf_ocid[gi*OC_W +: OC_W]      = rf_ocid_q;
        assign rf_wdata[gi*DATA_W +: DATA_W] = rf_wdata_q;
    end

endmodule

// File: tb/tb_reqfifo_banked.sv
// Directed scenarios plus random traffic, checked every cycle against a queue-based
// model of the banked request FIFO.
module tb_reqfifo_banked;

    localparam int NB = 4, RW = 3, OW = 3, DEPTH = 4, DW = 256, SMAX = 3, BW = 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   src1_valid, src2_valid, wr_valid;
    logic [BW-1:0]          src1_bank, src2_bank, wr_bank;
    logic [RW-1:0]          src1_row, src2_row, wr_row;
    logic [OW-1:0]          src1_ocid, src2_ocid;
    logic [DW-1:0]          wr_data;
    logic                   req_ready, wr_ready;
    logic [NB-1:0]          rf_valid, rf_wr;
    logic [NB*RW-1:0]       rf_addr;
    logic [NB*(OW+1)-1:0]   rf_ocid;
    logic [NB*DW-1:0]       rf_wdata;

    always #5 clk = ~clk;

    reqfifo_banked #(
        .NUM_BANKS(NB), .ROW_W(RW), .OCID_W(OW), .DEPTH(DEPTH), .DATA_W(DW), .STARVE_MAX(SMAX)
    ) dut (
        .clk(clk), .rst(rst),
        .src1_valid(src1_valid), .src1_bank(src1_bank), .src1_row(src1_row), .src1_ocid(src1_ocid),
        .src2_valid(src2_valid), .src2_bank(src2_bank), .src2_row(src2_row), .src2_ocid(src2_ocid),
        .req_ready(req_ready),
        .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_row(wr_row), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .rf_valid(rf_valid), .rf_wr(rf_wr), .rf_addr(rf_addr), .rf_ocid(rf_ocid), .rf_wdata(rf_wdata)
    );

    typedef struct packed {
        logic [RW-1:0] row;
        logic [OW-1:0] ocid;
        logic          sel;
    } ment_t;

    ment_t                mq [NB][$];
    int                   starve [NB];
    logic [NB-1:0]        exp_valid, exp_wr;
    logic [NB*RW-1:0]     exp_addr;
    logic [NB*(OW+1)-1:0] exp_ocid;
    logic [NB*DW-1:0]     exp_wdata;
    logic                 last_rdy, last_wok;
    int                   n_cmp = 0;
    int                   n_bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int b = 0; b < NB; b++) begin
            mq[b].delete();
            starve[b] = 0;
        end
    endtask

    task automatic set_req(input logic v1, input int b1, input int r1, input int o1,
                           input logic v2, input int b2, input int r2, input int o2);
        src1_valid = v1; src1_bank = BW'(b1); src1_row = RW'(r1); src1_ocid = OW'(o1);
        src2_valid = v2; src2_bank = BW'(b2); src2_row = RW'(r2); src2_ocid = OW'(o2);
    endtask

    task automatic set_wr(input logic v, input int b, input int r, input logic [DW-1:0] d);
        wr_valid = v; wr_bank = BW'(b); wr_row = RW'(r); wr_data = d;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    task automatic idle();
        set_req(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
        set_wr(1'b0, 0, 0, '0);
    endtask

    // One clock: check the ready outputs, advance the model, then check rf_* at the next negedge.
    task automatic step();
        int    need [NB];
        bit    rdy, wok, blk;
        ment_t e;
        #1;
        for (int b = 0; b < NB; b++)
            need[b] = int'(src1_valid && src1_bank == BW'(b)) + int'(src2_valid && src2_bank == BW'(b));
        rdy = 1'b1;
        for (int b = 0; b < NB; b++)
            if (DEPTH - mq[b].size() < need[b]) rdy = 1'b0;
        wok = !(starve[wr_bank] == SMAX && mq[wr_bank].size() != 0);
        chk("req_ready", req_ready, rdy);
        chk("wr_ready", wr_ready, wok);
        last_rdy = req_ready;
        last_wok = wr_ready;

        exp_valid = '0; exp_wr = '0; exp_addr = '0; exp_ocid = '0; exp_wdata = '0;
        for (int b = 0; b < NB; b++) begin
            blk = (starve[b] == SMAX && mq[b].size() != 0);
            if (wr_valid && wr_bank == BW'(b) && !blk) begin
                exp_valid[b] = 1'b1;
                exp_wr[b]    = 1'b1;
                exp_addr[b*RW +: RW] = wr_row;
                exp_wdata[b*DW +: DW] = wr_data;
                starve[b] = (mq[b].size() != 0) ? ((starve[b] < SMAX) ? starve[b] + 1 : SMAX) : 0;
            end else if (mq[b].size() != 0) begin
                e = mq[b].pop_front();
                exp_valid[b] = 1'b1;
                exp_addr[b*RW +: RW] = e.row;
                exp_ocid[b*(OW+1) +: OW+1] = {e.sel, e.ocid};
                starve[b] = 0;
            end else begin
                starve[b] = 0;
            end
        end
        if (rdy && (src1_valid || src2_valid)) begin
            if (src1_valid) mq[src1_bank].push_back('{row: src1_row, ocid: src1_ocid, sel: 1'b0});
            if (src2_valid) mq[src2_bank].push_back('{row: src2_row, ocid: src2_ocid, sel: 1'b1});
        end

        @(negedge clk);
        chk("rf_valid", rf_valid, exp_valid);
        chk("rf_wr", rf_wr, exp_wr);
        chk("rf_addr", rf_addr, exp_addr);
        chk("rf_ocid", rf_ocid, exp_ocid);
        for (int b = 0; b < NB; b++)
            chk($sformatf("rf_wdata%0d", b), rf_wdata[b*DW +: DW], exp_wdata[b*DW +: DW]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, rf_valid, '0);
        chk({tag, "_wr"}, rf_wr, '0);
        chk({tag, "_addr"}, rf_addr, '0);
        chk({tag, "_ocid"}, rf_ocid, '0);
        chk({tag, "_wdata"}, DW'(|rf_wdata), '0);
    endtask

    int pat_wok [5] = '{1, 1, 1, 0, 1};

    initial begin
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst = 1'b0;
        model_clear();
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_wr_ready", wr_ready, 1);

        // Single read: two cycles from request to rf_*.
        set_req(1'b1, 2, 5, 3, 1'b0, 0, 0, 0); step();
        idle(); step();
        chk("t1_valid", rf_valid, 4'b0100);
        chk("t1_wr", rf_wr, 0);
        chk("t1_addr", rf_addr[2*RW +: RW], 5);
        chk("t1_ocid", rf_ocid[2*(OW+1) +: OW+1], 4'b0011);

        // Both sources into bank 1 in one cycle.
        set_req(1'b1, 1, 1, 2, 1'b1, 1, 4, 6); step();
        idle(); step();
        chk("t2_a_valid", rf_valid, 4'b0010);
        chk("t2_a_addr", rf_addr[1*RW +: RW], 1);
        chk("t2_a_ocid", rf_ocid[1*(OW+1) +: OW+1], 4'b0010);
        step();
        chk("t2_b_valid", rf_valid, 4'b0010);
        chk("t2_b_addr", rf_addr[1*RW +: RW], 4);
        chk("t2_b_ocid", rf_ocid[1*(OW+1) +: OW+1], 4'b1110);
        step();

        // Fill bank 0 to three entries while writes hold the port, then offer a dual push.
        set_req(1'b1, 0, 0, 1, 1'b1, 0, 1, 2); set_wr(1'b1, 0, 2, rand_data()); step();
        set_req(1'b1, 0, 3, 3, 1'b0, 0, 0, 0); set_wr(1'b1, 0, 4, rand_data()); step();
        set_req(1'b1, 0, 4, 4, 1'b1, 0, 5, 5); set_wr(1'b1, 0, 6, rand_data()); step();
        chk("t3_full_wr", last_rdy, 0);
        set_wr(1'b0, 0, 0, '0); step();
        chk("t3_full_pop", last_rdy, 0);
        step();
        chk("t3_room", last_rdy, 1);
        idle();
        repeat (6) step();

        // Write into an empty bank.
        set_wr(1'b1, 3, 7, {DW{1'b1}}); step();
        chk("t4_wok", last_wok, 1);
        chk("t4_wr", rf_wr, 4'b1000);
        chk("t4_addr", rf_addr[3*RW +: RW], 7);
        chk("t4_wdata", rf_wdata[3*DW +: DW], {DW{1'b1}});
        idle(); step();

        // Starvation guard on bank 0.
        set_req(1'b1, 0, 6, 7, 1'b0, 0, 0, 0); step();
        idle(); set_wr(1'b1, 0, 1, rand_data());
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t5_wok%0d", i), last_wok, pat_wok[i]);
            chk($sformatf("t5_rfwr%0d", i), rf_wr[0], pat_wok[i]);
        end
        idle(); repeat (2) step();

        // Reset with three reads queued in bank 2.
        set_req(1'b1, 2, 1, 1, 1'b1, 2, 2, 2); set_wr(1'b1, 2, 3, rand_data()); step();
        set_req(1'b1, 2, 3, 3, 1'b0, 0, 0, 0); set_wr(1'b1, 2, 5, rand_data()); step();
        idle();
        rst = 1'b1;
        #1;
        chk_all_zero("t6_rst");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("t6_stale%0d", i), rf_valid, 0);
        end

        // Random traffic; an unaccepted write is held and retried like the CDB does.
        for (int n = 0; n < 600; n++) begin
            set_req($urandom_range(0, 1) == 1, $urandom_range(0, NB-1), $urandom, $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, NB-1), $urandom, $urandom);
            if (!(wr_valid && !last_wok)) begin
                set_wr($urandom_range(0, 2) != 0,
                       ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, NB-1),
                       $urandom, rand_data());
            end
            step();
        end
        idle();
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
